// File: rtl/systolic_stream_driver.sv
// Initiator for the systolic array stream port: holds operands A and B, streams them
// to the array over valid/ready and gathers the results over valid/yumi into a read buffer.
`timescale 1ns/1ps
module systolic_stream_driver #(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2,
   parameter int timeout_p      = 64,
   localparam int els_lp        = array_width_p * array_height_p,
   localparam int src_els_lp    = 2 * els_lp
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          load_v_i,
   input  logic [$clog2(src_els_lp)-1:0] load_addr_i,
   input  logic [width_p-1:0]            load_data_i,
   input  logic                          start_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          timeout_o,
   output logic                          flush_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [width_p-1:0]            data_o,
   input  logic                          valid_i,
   input  logic [width_p-1:0]            data_i,
   output logic                          yumi_o,
   input  logic [$clog2(els_lp)-1:0]     rd_addr_i,
   output logic [width_p-1:0]            rd_data_o,
   output logic [2:0]                    dbg_state_o
);

   localparam int src_aw_lp  = $clog2(src_els_lp);
   localparam int scnt_w_lp  = $clog2(src_els_lp + 1);
   localparam int rcnt_w_lp  = $clog2(els_lp + 1);
   localparam int icnt_w_lp  = $clog2(timeout_p + 1);
   localparam logic [scnt_w_lp-1:0] send_full_lp = scnt_w_lp'(src_els_lp);
   localparam logic [rcnt_w_lp-1:0] recv_full_lp = rcnt_w_lp'(els_lp);
   localparam logic [icnt_w_lp-1:0] idle_full_lp = icnt_w_lp'(timeout_p);
   localparam logic [src_aw_lp-1:0] src_first_lp = '0;

   typedef enum logic [2:0] {
      IDLE_S  = 3'd0,
      FLUSH_S = 3'd1,
      SEND_S  = 3'd2,
      DRAIN_S = 3'd3,
      DONE_S  = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [scnt_w_lp-1:0]   send_cnt_q, send_cnt_d;
   logic [rcnt_w_lp-1:0]   recv_cnt_q, recv_cnt_d;
   logic [icnt_w_lp-1:0]   idle_cnt_q, idle_cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_q, timeout_d;
   logic                   flush_q, flush_d;
   logic                   valid_q, valid_d;
   logic [width_p-1:0]     data_q, data_d;
   logic [width_p-1:0]     src_mem_q [src_els_lp];
   logic [width_p-1:0]     src_mem_d [src_els_lp];
   logic [width_p-1:0]     res_mem_q [els_lp];
   logic [width_p-1:0]     res_mem_d [els_lp];
   logic                   send_xfer;
   logic                   yumi;

   // Handshakes: an operand word moves on a cycle where valid_o && ready_i; a result word
   // moves on a cycle where yumi_o is high, and yumi_o is only ever raised while valid_i is high.
   always_comb begin
      state_d    = state_q;
      send_cnt_d = send_cnt_q;
      recv_cnt_d = recv_cnt_q;
      idle_cnt_d = idle_cnt_q;
      busy_d     = busy_q;
      done_d     = done_q;
      timeout_d  = timeout_q;
      flush_d    = 1'b0;
      valid_d    = valid_q;
      data_d     = data_q;
      src_mem_d  = src_mem_q;
      res_mem_d  = res_mem_q;
      send_xfer  = 1'b0;
      yumi       = 1'b0;

      case (state_q)
         IDLE_S, DONE_S: begin
            if (load_v_i) begin
               src_mem_d[load_addr_i] = load_data_i;
            end
            if (start_i) begin
               state_d    = FLUSH_S;
               flush_d    = 1'b1;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               timeout_d  = 1'b0;
               send_cnt_d = '0;
               recv_cnt_d = '0;
               idle_cnt_d = '0;
            end
         end

         FLUSH_S: begin
            state_d = SEND_S;
            valid_d = 1'b1;
            data_d  = src_mem_q[src_first_lp];
         end

         SEND_S, DRAIN_S: begin
            send_xfer = (state_q == SEND_S) && valid_q && ready_i;
            yumi      = valid_i && (recv_cnt_q < recv_full_lp);

            if (send_xfer) begin
               send_cnt_d = send_cnt_q + scnt_w_lp'(1);
               if (send_cnt_d == send_full_lp) begin
                  valid_d = 1'b0;
                  state_d = DRAIN_S;
               end else begin
                  data_d = src_mem_q[send_cnt_d[src_aw_lp-1:0]];
               end
            end

            if (yumi) begin
               res_mem_d[recv_cnt_q[$clog2(els_lp)-1:0]] = data_i;
               recv_cnt_d = recv_cnt_q + rcnt_w_lp'(1);
            end

            if (send_xfer || yumi) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + icnt_w_lp'(1);
            end

            // Normal completion takes priority over a timeout landing on the same cycle.
            if ((send_cnt_d == send_full_lp) && (recv_cnt_d == recv_full_lp)) begin
               state_d = DONE_S;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               valid_d = 1'b0;
            end else if (idle_cnt_d == idle_full_lp) begin
               state_d   = DONE_S;
               done_d    = 1'b1;
               timeout_d = 1'b1;
               busy_d    = 1'b0;
               valid_d   = 1'b0;
            end
         end

         default: begin
            state_d = IDLE_S;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE_S;
         send_cnt_q <= '0;
         recv_cnt_q <= '0;
         idle_cnt_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         flush_q    <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         res_mem_q  <= '{default: '0};
      end else begin
         state_q    <= state_d;
         send_cnt_q <= send_cnt_d;
         recv_cnt_q <= recv_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
         flush_q    <= flush_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         res_mem_q  <= res_mem_d;
      end
   end

   // Operand storage survives reset so a host can reload only what changed.
   always_ff @(posedge clk_i) begin
      src_mem_q <= src_mem_d;
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign timeout_o   = timeout_q;
   assign flush_o     = flush_q;
   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign yumi_o      = yumi;
   assign rd_data_o   = res_mem_q[rd_addr_i];
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_systolic_stream_driver.sv
// Directed bench for systolic_stream_driver: operand words are scoreboarded against an
// expected queue, status/readback expectations are queued by stimulus and checked by the monitor.
`timescale 1ns/1ps
module tb_systolic_stream_driver;

   localparam int W   = 8;
   localparam int ELS = 4;
   localparam int SRC = 8;

   localparam int S_BUSY  = 0;
   localparam int S_DONE  = 1;
   localparam int S_TMO   = 2;
   localparam int S_FLUSH = 3;
   localparam int S_VALID = 4;
   localparam int S_DATA  = 5;
   localparam int S_YUMI  = 6;
   localparam int S_RD    = 7;
   localparam int S_XFERS = 8;
   localparam int S_QSIZE = 9;
   localparam int S_WAIT  = 10;

   typedef struct {
      int          sig;
      logic [31:0] val;
   } stat_t;

   logic         clk_i = 1'b0;
   logic         reset_n_i = 1'b0;
   logic         load_v_i = 1'b0;
   logic [2:0]   load_addr_i = '0;
   logic [W-1:0] load_data_i = '0;
   logic         start_i = 1'b0;
   logic         busy_o, done_o, timeout_o, flush_o, valid_o, yumi_o;
   logic         ready_i = 1'b0;
   logic [W-1:0] data_o;
   logic         valid_i = 1'b0;
   logic [W-1:0] data_i = '0;
   logic [1:0]   rd_addr_i = '0;
   logic [W-1:0] rd_data_o;
   logic [2:0]   dbg_state_o;

   logic [W-1:0] exp_q[$];
   stat_t        stat_q[$];
   int           checks = 0;
   int           errors = 0;
   int           xfer_cnt = 0;
   int           exp_xfers = 0;
   logic         wait_expired = 1'b0;
   logic [W-1:0] src_m [SRC];
   logic [W-1:0] prod_m [ELS];
   logic [W-1:0] mon_e;
   logic [31:0]  mon_act;
   stat_t        mon_s;

   systolic_stream_driver #(
      .width_p(W), .array_width_p(2), .array_height_p(2), .timeout_p(64)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .load_v_i(load_v_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
      .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
      .flush_o(flush_o), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
      .valid_i(valid_i), .data_i(data_i), .yumi_o(yumi_o),
      .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .dbg_state_o(dbg_state_o)
   );

   // Clock and watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic string sig_name(input int sig);
      case (sig)
         S_BUSY:  return "busy_o";
         S_DONE:  return "done_o";
         S_TMO:   return "timeout_o";
         S_FLUSH: return "flush_o";
         S_VALID: return "valid_o";
         S_DATA:  return "data_o";
         S_YUMI:  return "yumi_o";
         S_RD:    return "rd_data_o";
         S_XFERS: return "operand_transfers";
         S_QSIZE: return "pending_operands";
         default: return "wait_bound";
      endcase
   endfunction

   function automatic logic [31:0] sample(input int sig);
      case (sig)
         S_BUSY:  return {31'd0, busy_o};
         S_DONE:  return {31'd0, done_o};
         S_TMO:   return {31'd0, timeout_o};
         S_FLUSH: return {31'd0, flush_o};
         S_VALID: return {31'd0, valid_o};
         S_DATA:  return {24'd0, data_o};
         S_YUMI:  return {31'd0, yumi_o};
         S_RD:    return {24'd0, rd_data_o};
         S_XFERS: return 32'(xfer_cnt);
         S_QSIZE: return 32'(exp_q.size());
         default: return {31'd0, wait_expired};
      endcase
   endfunction

   // Monitor / scoreboard: the only process that counts comparisons
   always @(negedge clk_i) begin
      if (reset_n_i && valid_o && ready_i) begin
         checks++;
         xfer_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL operand_extra got %0d required none", data_o);
         end else begin
            mon_e = exp_q.pop_front();
            if (data_o !== mon_e) begin
               errors++;
               $display("FAIL operand_word got %0d required %0d", data_o, mon_e);
            end
         end
      end else if (reset_n_i && valid_o && !ready_i && exp_q.size() > 0) begin
         checks++;
         if (data_o !== exp_q[0]) begin
            errors++;
            $display("FAIL operand_hold got %0d required %0d", data_o, exp_q[0]);
         end
      end
      while (stat_q.size() > 0) begin
         mon_s   = stat_q.pop_front();
         mon_act = sample(mon_s.sig);
         checks++;
         if (mon_act !== mon_s.val) begin
            errors++;
            $display("FAIL %s got %0d required %0d at %0t", sig_name(mon_s.sig), mon_act, mon_s.val, $time);
         end
      end
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic expect_sig(input int sig, input int val);
      stat_q.push_back('{sig, 32'(val)});
   endtask

   task automatic expect_idle_outputs();
      expect_sig(S_BUSY, 0);
      expect_sig(S_DONE, 0);
      expect_sig(S_TMO, 0);
      expect_sig(S_FLUSH, 0);
      expect_sig(S_VALID, 0);
      expect_sig(S_DATA, 0);
   endtask

   task automatic load_word(input int addr, input logic [W-1:0] d);
      load_v_i    = 1'b1;
      load_addr_i = 3'(addr);
      load_data_i = d;
      tick();
      load_v_i    = 1'b0;
   endtask

   task automatic push_ops(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(src_m[i]);
   endtask

   task automatic start_run();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      expect_sig(S_FLUSH, 1);
      expect_sig(S_VALID, 0);
      expect_sig(S_BUSY, 1);
      expect_sig(S_DONE, 0);
      expect_sig(S_TMO, 0);
      tick();
   endtask

   task automatic wait_sent(input int bound);
      int n = 0;
      while (exp_q.size() > 0 && n < bound) begin
         tick();
         n++;
      end
      wait_expired = (exp_q.size() > 0);
      expect_sig(S_WAIT, 0);
   endtask

   task automatic drive_res(input logic [W-1:0] d, input int exp_yumi);
      valid_i = 1'b1;
      data_i  = d;
      expect_sig(S_YUMI, exp_yumi);
      tick();
      valid_i = 1'b0;
   endtask

   task automatic expect_rd(input int addr, input logic [W-1:0] v);
      rd_addr_i = 2'(addr);
      expect_sig(S_RD, int'(v));
      tick();
   endtask

   task automatic finish_with_products();
      for (int k = 0; k < ELS; k++) drive_res(prod_m[k], 1);
      exp_xfers += SRC;
      expect_sig(S_DONE, 1);
      expect_sig(S_TMO, 0);
      expect_sig(S_BUSY, 0);
      expect_sig(S_VALID, 0);
      expect_sig(S_XFERS, exp_xfers);
      tick();
   endtask

   // Stimulus
   initial begin
      for (int i = 0; i < SRC; i++) src_m[i] = W'(i + 1);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            prod_m[r*2+c] = src_m[r*2] * src_m[ELS+c] + src_m[r*2+1] * src_m[ELS+2+c];

      // Reset state, then release
      expect_idle_outputs();
      expect_sig(S_RD, 0);
      tick();
      tick();
      reset_n_i = 1'b1;
      expect_idle_outputs();
      tick();
      for (int i = 0; i < SRC; i++) load_word(i, src_m[i]);

      // 1: no responder -> timeout 64 cycles after entering SEND
      ready_i = 1'b0;
      start_run();
      expect_sig(S_VALID, 1);
      expect_sig(S_DATA, 1);
      expect_sig(S_FLUSH, 0);
      for (int i = 0; i < 63; i++) tick();
      expect_sig(S_DONE, 0);
      expect_sig(S_VALID, 1);
      tick();
      expect_sig(S_DONE, 1);
      expect_sig(S_TMO, 1);
      expect_sig(S_VALID, 0);
      expect_sig(S_BUSY, 0);
      expect_sig(S_XFERS, 0);
      tick();

      // 2: full run, 8 consecutive operand words, results read back
      push_ops(SRC);
      ready_i = 1'b1;
      start_run();
      for (int i = 0; i < SRC; i++) begin
         expect_sig(S_VALID, 1);
         tick();
      end
      expect_sig(S_VALID, 0);
      expect_sig(S_BUSY, 1);
      expect_sig(S_QSIZE, 0);
      finish_with_products();
      for (int k = 0; k < ELS; k++) expect_rd(k, prod_m[k]);

      // 3: backpressure, ready toggling every cycle
      push_ops(SRC);
      ready_i = 1'b0;
      start_run();
      begin
         int n = 0;
         while (exp_q.size() > 0 && n < 40) begin
            ready_i = n[0];
            tick();
            n++;
         end
         wait_expired = (exp_q.size() > 0);
         expect_sig(S_WAIT, 0);
      end
      ready_i = 1'b0;
      finish_with_products();

      // 4: early results during SEND, excess result refused
      push_ops(SRC);
      start_run();
      drive_res(8'hAA, 1);
      drive_res(8'h11, 1);
      drive_res(8'h22, 1);
      drive_res(8'h33, 1);
      expect_sig(S_BUSY, 1);
      drive_res(8'h44, 0);
      ready_i = 1'b1;
      wait_sent(30);
      exp_xfers += SRC;
      expect_sig(S_DONE, 1);
      expect_sig(S_TMO, 0);
      expect_sig(S_BUSY, 0);
      expect_sig(S_XFERS, exp_xfers);
      tick();
      expect_rd(0, 8'hAA);
      expect_rd(1, 8'h11);
      expect_rd(2, 8'h22);
      expect_rd(3, 8'h33);

      // 5: start and load during SEND are ignored
      push_ops(SRC);
      ready_i = 1'b0;
      start_run();
      start_i     = 1'b1;
      load_v_i    = 1'b1;
      load_addr_i = 3'd0;
      load_data_i = 8'hFF;
      tick();
      start_i  = 1'b0;
      load_v_i = 1'b0;
      expect_sig(S_FLUSH, 0);
      expect_sig(S_VALID, 1);
      expect_sig(S_DATA, 1);
      expect_sig(S_BUSY, 1);
      ready_i = 1'b1;
      wait_sent(30);
      ready_i = 1'b0;
      finish_with_products();

      // 6: reset after 3 transfers, then a fresh run from src[0]
      push_ops(3);
      start_run();
      ready_i = 1'b1;
      tick();
      tick();
      tick();
      ready_i   = 1'b0;
      reset_n_i = 1'b0;
      exp_xfers += 3;
      expect_idle_outputs();
      expect_sig(S_XFERS, exp_xfers);
      expect_sig(S_QSIZE, 0);
      for (int k = 0; k < ELS; k++) expect_rd(k, 8'h00);
      reset_n_i = 1'b1;
      tick();
      push_ops(SRC);
      ready_i = 1'b1;
      start_run();
      wait_sent(30);
      ready_i = 1'b0;
      finish_with_products();
      for (int k = 0; k < ELS; k++) expect_rd(k, prod_m[k]);

      // Final report
      expect_sig(S_QSIZE, 0);
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_stream_driver.md
Name: systolic_stream_driver

Overview:
- Initiator-side counterpart to the systolic array `top` stream port.
- Holds operand matrices A and B, written through a load port, and streams them into `top` over valid/ready.
- Collects the `top` result stream over valid/yumi into a readable result buffer, and signals done or timeout.
- Sits between a host/CSR block and `top`, replacing bench-driven stimulus in system builds.

Parameters:
- width_p, 8, data word width.
- array_width_p, 2, systolic array columns.
- array_height_p, 2, systolic array rows.
- timeout_p, 64, idle cycles (no transfer on either stream) before abort.
- Derived: els_lp = array_width_p*array_height_p; src_els_lp = 2*els_lp.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- load_v_i  in  1  write strobe into source buffer.
- load_addr_i  in  $clog2(src_els_lp)  source address; 0..els_lp-1 = A, els_lp..src_els_lp-1 = B, each row-major.
- load_data_i  in  width_p  source write data.
- start_i  in  1  begin a run (single-cycle pulse).
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until next accepted start.
- timeout_o  out  1  last run aborted on idle timeout; held until next accepted start.
- flush_o  out  1  one-cycle flush to `top` at run start.
- valid_o  out  1  operand word valid to `top`.
- ready_i  in  1  `top` ready for an operand word.
- data_o  out  width_p  operand word.
- valid_i  in  1  result word valid from `top`.
- data_i  in  width_p  result word.
- yumi_o  out  1  result word consumed this cycle.
- rd_addr_i  in  $clog2(els_lp)  result buffer read address.
- rd_data_o  out  width_p  result word at rd_addr_i (combinational read).

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - FSM goes to IDLE; all counters 0; result buffer cleared to 0.
  - busy_o, done_o, timeout_o, flush_o, valid_o = 0; data_o = 0.
  - Source buffer is not reset.
- Reset asserted mid-run aborts the run immediately; no partial done_o.
- States: IDLE, FLUSH, SEND, DRAIN, DONE.
- IDLE/DONE:
  - load_v_i writes the source buffer.
  - start_i moves to FLUSH, clears done_o and timeout_o, zeroes send_cnt, recv_cnt and idle_cnt.
- FLUSH (exactly 1 cycle):
  - flush_o = 1, valid_o = 0, busy_o = 1; next state is SEND.
- SEND:
  - valid_o = 1; data_o = src[send_cnt], registered.
  - Transfer when valid_o && ready_i; send_cnt increments and data_o advances to the next word on the following cycle.
  - data_o stays stable while valid_o && !ready_i.
  - After transfer of word src_els_lp-1, go to DRAIN and deassert valid_o.
- DRAIN: valid_o = 0; wait for results.
- Result capture, active in SEND and DRAIN:
  - yumi_o = valid_i && (recv_cnt < els_lp); combinational, no added latency.
  - On yumi_o, res[recv_cnt] <= data_i and recv_cnt increments.
  - Results arriving before SEND completes are accepted.
  - valid_i outside SEND/DRAIN, or after els_lp results, is never acknowledged.
- Completion:
  - When recv_cnt reaches els_lp and send_cnt reaches src_els_lp, go to DONE; done_o = 1, busy_o = 0.
  - If the last result and the last operand transfer occur in the same cycle, DONE is entered the next cycle.
- Timeout:
  - idle_cnt increments each SEND/DRAIN cycle with no operand transfer and no yumi_o; it resets to 0 on either transfer.
  - When idle_cnt reaches timeout_p, go to DONE with timeout_o = 1 and done_o = 1; valid_o drops.
  - Captured results are retained.
- Ignored inputs:
  - start_i while busy_o is ignored.
  - load_v_i while busy_o is ignored; the source buffer is unchanged.
- rd_data_o is valid in every state; reading during a run may return stale or partial data.
- Counters are sized to count to src_els_lp and els_lp without wrap; no arithmetic is performed on data words.

Test Plan:
1. Reset then idle: release reset_n_i -> all outputs 0, FSM in IDLE. Pulse start_i with no responder (ready_i = 0, valid_i = 0) -> flush_o for 1 cycle, valid_o = 1 with data_o = src[0], timeout_o = done_o = 1 exactly 64 cycles after entering SEND.
2. Full run, 2x2:
   - Load A = {1,2,3,4}, B = {5,6,7,8}; ready_i = 1 constantly.
   - Required: data_o sequence 1..8 on 8 consecutive cycles.
   - A responder model returns {19,22,43,50} -> res buffer reads back 19,22,43,50.
   - done_o = 1, timeout_o = 0.
3. Backpressure: toggle ready_i 1/0 each cycle -> data_o held while !ready_i, no word skipped or duplicated, exactly 8 transfers.
4. Early/excess results:
   - valid_i high with 0xAA during SEND -> accepted into res[0].
   - A 5th valid_i after 4 results -> yumi_o = 0.
5. Ignored start/load: start_i and load_v_i (addr 0, data 0xFF) during SEND -> run unaffected, src[0] still 1 on the next run.
6. Mid-run reset: assert reset_n_i low while in SEND after 3 transfers -> valid_o, busy_o drop asynchronously, res buffer reads 0. A new start streams from src[0].
